// File: rtl/jesd204_versal_gt_pkg.sv
// Shared constants and small helpers for the JESD204 Versal GT lane adapters.
package jesd204_versal_gt_pkg;

  localparam int LINK_MODE_8B10B  = 1;
  localparam int LINK_MODE_64B66B = 2;

  // Last external-gearbox sequence value; the GT ignores txdata in that slot.
  localparam int SEQ_PAUSE = 32;
  localparam int SEQ_WIDTH = 7;

  // 64B66B sync headers in link-layer bit order.
  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  // The GT gearbox transmits MSB first while the link layer is LSB first.
  function automatic logic [63:0] bit_reverse64(input logic [63:0] value);
    logic [63:0] result;
    result = 64'd0;
    for (int i = 0; i < 64; i++) begin
      result[63-i] = value[i];
    end
    return result;
  endfunction

  // Sync header uses the same reversed transmission order as the payload.
  function automatic logic [1:0] swap_header(input logic [1:0] hdr);
    return {hdr[0], hdr[1]};
  endfunction

endpackage

// File: rtl/jesd204_versal_gt_adapter_tx_if.sv
// Link-layer word handshake between the JESD204 TX core and the GT adapter.
interface jesd204_versal_gt_adapter_tx_if;

  logic [63:0] tx_data;
  logic [1:0]  tx_header;
  logic [3:0]  tx_charisk;
  logic        tx_valid;
  logic        tx_ready;

  // Link layer side: presents words, observes back-pressure.
  modport master (
    output tx_data,
    output tx_header,
    output tx_charisk,
    output tx_valid,
    input  tx_ready
  );

  // Adapter side: consumes words, applies back-pressure.
  modport slave (
    input  tx_data,
    input  tx_header,
    input  tx_charisk,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/jesd204_versal_gt_adapter_tx_seq_counter.sv
// External gearbox sequence counter: counts 0..PAUSE and wraps, and flags the
// cycle before the pause slot so the word source can be held off.
module jesd204_gt_tx_seq_counter
  import jesd204_versal_gt_pkg::*;
#(
  parameter int PAUSE     = SEQ_PAUSE,
  parameter int CNT_WIDTH = SEQ_WIDTH - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] seq_cnt,
  output logic                 pause_next
);

  localparam logic [CNT_WIDTH-1:0] PAUSE_VAL = CNT_WIDTH'(PAUSE);
  localparam logic [CNT_WIDTH-1:0] PRE_PAUSE = CNT_WIDTH'(PAUSE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};

  logic [CNT_WIDTH-1:0] seq_cnt_r;

  // Advance while enabled, wrap after the pause slot, restart at 0 when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      seq_cnt_r <= CNT_ZERO;
    end else if (!enable) begin
      seq_cnt_r <= CNT_ZERO;
    end else if (seq_cnt_r == PAUSE_VAL) begin
      seq_cnt_r <= CNT_ZERO;
    end else begin
      seq_cnt_r <= seq_cnt_r + CNT_ONE;
    end
  end

  // A word accepted now would land in the pause slot, so flag it.
  always_comb begin
    pause_next = 1'b0;
    if (seq_cnt_r == PRE_PAUSE) begin
      pause_next = 1'b1;
    end else begin
      pause_next = 1'b0;
    end
  end

  assign seq_cnt = seq_cnt_r;

endmodule

// File: rtl/jesd204_versal_gt_adapter_tx.sv
// TX adapter from the JESD204 link layer onto one Versal GT transmitter lane.
// 64B66B drives the synchronous gearbox in external-sequence mode; 8B10B
// registers data and charisk. Traffic is gated until the GT is out of reset.
module jesd204_versal_gt_adapter_tx
  import jesd204_versal_gt_pkg::*;
#(
  parameter int LINK_MODE = LINK_MODE_64B66B,
  parameter int SEQ_PAUSE = 32
) (
  input  logic                 usr_clk,
  input  logic                 reset,
  input  logic                 tx_gt_ready,
  jesd204_versal_gt_adapter_tx_if.slave link,
  output logic                 tx_underflow,
  output logic [127:0]         txdata,
  output logic [5:0]           txheader,
  output logic [SEQ_WIDTH-1:0] txsequence,
  output logic [15:0]          txctrl0,
  output logic [15:0]          txctrl1,
  output logic [7:0]           txctrl2
);

  localparam int CNT_WIDTH = SEQ_WIDTH - 1;
  localparam bit IS_64B66B = (LINK_MODE == LINK_MODE_64B66B);

  logic                 run_s;
  logic                 count_en_s;
  logic                 pause_next_s;
  logic                 tx_ready_s;
  logic [CNT_WIDTH-1:0] seq_cnt_s;

  logic [127:0]         txdata_r;
  logic [5:0]           txheader_r;
  logic [7:0]           txctrl2_r;
  logic                 underflow_r;

  assign run_s      = ~reset & tx_gt_ready;
  assign count_en_s = run_s & IS_64B66B;

  jesd204_gt_tx_seq_counter #(
    .PAUSE     (SEQ_PAUSE),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_seq_counter (
    .clk        (usr_clk),
    .reset      (reset),
    .enable     (count_en_s),
    .seq_cnt    (seq_cnt_s),
    .pause_next (pause_next_s)
  );

  // Back-pressure: only the slot before the gearbox pause refuses a word.
  always_comb begin
    tx_ready_s = 1'b0;
    if (IS_64B66B) begin
      tx_ready_s = run_s & ~pause_next_s;
    end else begin
      tx_ready_s = run_s;
    end
  end

  // GT output register: map accepted words, fill underflow gaps with an
  // idle data block, and hold across the pause slot.
  always_ff @(posedge usr_clk) begin
    if (reset) begin
      txdata_r    <= 128'd0;
      txheader_r  <= 6'd0;
      txctrl2_r   <= 8'd0;
      underflow_r <= 1'b0;
    end else if (!tx_gt_ready) begin
      txdata_r    <= 128'd0;
      txheader_r  <= 6'd0;
      txctrl2_r   <= 8'd0;
    end else if (tx_ready_s) begin
      if (link.tx_valid) begin
        if (IS_64B66B) begin
          txdata_r   <= {64'd0, bit_reverse64(link.tx_data)};
          txheader_r <= {4'd0, swap_header(link.tx_header)};
          txctrl2_r  <= 8'd0;
        end else begin
          txdata_r   <= {96'd0, link.tx_data[31:0]};
          txheader_r <= 6'd0;
          txctrl2_r  <= {4'd0, link.tx_charisk};
        end
      end else begin
        txdata_r    <= 128'd0;
        txheader_r  <= IS_64B66B ? {4'd0, swap_header(HDR_DATA)} : 6'd0;
        txctrl2_r   <= 8'd0;
        underflow_r <= 1'b1;
      end
    end
  end

  assign link.tx_ready = tx_ready_s;
  assign tx_underflow  = underflow_r;
  assign txdata        = txdata_r;
  assign txheader      = txheader_r;
  assign txsequence    = {1'b0, seq_cnt_s};
  assign txctrl0       = 16'h0000;
  assign txctrl1       = 16'h0000;
  assign txctrl2       = txctrl2_r;

endmodule

// File: tb/tb_jesd204_versal_gt_adapter_tx.sv
// Scoreboard bench: a 64B66B and an 8B10B adapter share one clock and are
// checked against a slot-level reference model.
module tb_jesd204_versal_gt_adapter_tx;

  localparam int PAUSE = 32;

  typedef struct packed {
    logic [127:0] data;
    logic [5:0]   hdr;
    logic [6:0]   seq;
    logic [7:0]   ctrl2;
    logic [15:0]  ctrl0;
    logic [15:0]  ctrl1;
    logic         uf;
  } exp_t;

  logic usr_clk = 1'b0;
  logic reset;
  logic tx_gt_ready;

  jesd204_versal_gt_adapter_tx_if lk64 ();
  jesd204_versal_gt_adapter_tx_if lk8 ();

  logic         uf64, uf8;
  logic [127:0] data64, data8;
  logic [5:0]   hdr64, hdr8;
  logic [6:0]   seq64, seq8;
  logic [15:0]  c0_64, c1_64, c0_8, c1_8;
  logic [7:0]   c2_64, c2_8;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   m_seq = 0;
  int   acc_cnt = 0;
  exp_t exp64 = '0;
  exp_t exp8 = '0;
  exp_t q64[$];
  exp_t q8[$];

  always #5 usr_clk = ~usr_clk;

  jesd204_versal_gt_adapter_tx #(.LINK_MODE(2), .SEQ_PAUSE(PAUSE)) dut64 (
    .usr_clk(usr_clk), .reset(reset), .tx_gt_ready(tx_gt_ready), .link(lk64),
    .tx_underflow(uf64), .txdata(data64), .txheader(hdr64), .txsequence(seq64),
    .txctrl0(c0_64), .txctrl1(c1_64), .txctrl2(c2_64));

  jesd204_versal_gt_adapter_tx #(.LINK_MODE(1), .SEQ_PAUSE(PAUSE)) dut8 (
    .usr_clk(usr_clk), .reset(reset), .tx_gt_ready(tx_gt_ready), .link(lk8),
    .tx_underflow(uf8), .txdata(data8), .txheader(hdr8), .txsequence(seq8),
    .txctrl0(c0_8), .txctrl1(c1_8), .txctrl2(c2_8));

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  // One link-layer cycle: drive, check back-pressure, advance the model,
  // and queue the GT word expected after the coming edge.
  task automatic step(input bit rst_i, input bit gtr_i, input bit v_i,
                      input logic [63:0] d_i, input logic [1:0] h_i,
                      input logic [31:0] d8_i, input logic [3:0] k_i);
    bit run;
    bit rdy64;
    logic [63:0] rev_d;
    logic [1:0]  rev_h;
    @(negedge usr_clk);
    reset = rst_i;
    tx_gt_ready = gtr_i;
    lk64.tx_valid = v_i;
    lk64.tx_data = d_i;
    lk64.tx_header = h_i;
    lk64.tx_charisk = 4'($urandom);
    lk8.tx_valid = v_i;
    lk8.tx_data = {32'($urandom), d8_i};
    lk8.tx_header = 2'($urandom);
    lk8.tx_charisk = k_i;
    #1;
    run = !rst_i && gtr_i;
    rdy64 = run && (m_seq != PAUSE - 1);
    check("tx_ready_64b66b", 128'(lk64.tx_ready), 128'(rdy64));
    check("tx_ready_8b10b", 128'(lk8.tx_ready), 128'(run));
    if (lk64.tx_ready === 1'b1 && v_i) acc_cnt++;
    rev_d = {<<{d_i}};
    rev_h = {<<{h_i}};
    if (rst_i) begin
      exp64 = '0;
      exp8 = '0;
      m_seq = 0;
    end else if (!run) begin
      m_seq = 0;
      exp64.data = '0; exp64.hdr = '0; exp64.ctrl2 = '0;
      exp8.data = '0;  exp8.hdr = '0;  exp8.ctrl2 = '0;
    end else begin
      if (rdy64) begin
        if (v_i) begin
          exp64.data = {64'd0, rev_d};
          exp64.hdr = {4'd0, rev_h};
        end else begin
          exp64.data = '0;
          exp64.hdr = 6'b000010;
          exp64.uf = 1'b1;
        end
      end
      if (v_i) begin
        exp8.data = {96'd0, d8_i};
        exp8.ctrl2 = {4'd0, k_i};
      end else begin
        exp8.data = '0;
        exp8.ctrl2 = '0;
        exp8.uf = 1'b1;
      end
      m_seq = (m_seq + 1) % (PAUSE + 1);
    end
    exp64.seq = 7'(m_seq);
    exp8.seq = 7'd0;
    q64.push_back(exp64);
    q8.push_back(exp8);
  endtask

  task automatic rstep(input bit rst_i, input bit gtr_i, input bit v_i);
    step(rst_i, gtr_i, v_i, rnd64(), 2'($urandom), 32'($urandom), 4'($urandom));
  endtask

  task automatic after_edge();
    @(posedge usr_clk);
    #2;
  endtask

  // Compare every registered GT word against the queued expectation.
  task automatic monitor();
    exp_t e;
    exp_t g;
    forever begin
      @(posedge usr_clk);
      #1;
      if (q64.size() > 0) begin
        e = q64.pop_front();
        g = '{data: data64, hdr: hdr64, seq: seq64, ctrl2: c2_64, ctrl0: c0_64, ctrl1: c1_64, uf: uf64};
        tests_run++;
        if (g !== e) begin
          tests_failed++;
          $display("FAIL gt64 @%0t: got d=%h h=%b s=%0d c2=%h c0=%h c1=%h uf=%b expected d=%h h=%b s=%0d c2=%h c0=%h c1=%h uf=%b",
                   $time, g.data, g.hdr, g.seq, g.ctrl2, g.ctrl0, g.ctrl1, g.uf,
                   e.data, e.hdr, e.seq, e.ctrl2, e.ctrl0, e.ctrl1, e.uf);
        end
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        g = '{data: data8, hdr: hdr8, seq: seq8, ctrl2: c2_8, ctrl0: c0_8, ctrl1: c1_8, uf: uf8};
        tests_run++;
        if (g !== e) begin
          tests_failed++;
          $display("FAIL gt8 @%0t: got d=%h h=%b s=%0d c2=%h c0=%h c1=%h uf=%b expected d=%h h=%b s=%0d c2=%h c0=%h c1=%h uf=%b",
                   $time, g.data, g.hdr, g.seq, g.ctrl2, g.ctrl0, g.ctrl1, g.uf,
                   e.data, e.hdr, e.seq, e.ctrl2, e.ctrl0, e.ctrl1, e.uf);
        end
      end
    end
  endtask

  task automatic run_until_seq(input int target);
    for (int i = 0; i < 40 && m_seq != target; i++) rstep(1'b0, 1'b1, 1'b1);
    check("reach_seq", 128'(m_seq), 128'(target));
  endtask

  initial begin
    reset = 1'b1;
    tx_gt_ready = 1'b0;
    lk64.tx_valid = 1'b0; lk64.tx_data = '0; lk64.tx_header = '0; lk64.tx_charisk = '0;
    lk8.tx_valid = 1'b0;  lk8.tx_data = '0;  lk8.tx_header = '0;  lk8.tx_charisk = '0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) rstep(1'b1, 1'b1, 1'b1);
    after_edge();
    check("reset_txdata", data64, 128'd0);
    check("reset_txsequence", 128'(seq64), 128'd0);
    check("reset_underflow", 128'(uf64), 128'd0);

    // Continuous traffic: 32 words per 33 cycles
    acc_cnt = 0;
    repeat (33) rstep(1'b0, 1'b1, 1'b1);
    check("accepted_per_33", 128'(acc_cnt), 128'd32);
    repeat (40) rstep(1'b0, 1'b1, 1'b1);

    // Word around the pause slot
    run_until_seq(30);
    step(1'b0, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 2'b10, 32'd0, 4'd0);
    after_edge();
    check("seq30_word_seq", 128'(seq64), 128'd31);
    check("seq30_word_data", data64, 128'h0000_0000_0000_0000_F7B3_D591_E6A2_C480);
    rstep(1'b0, 1'b1, 1'b1);
    after_edge();
    check("pause_seq", 128'(seq64), 128'd32);
    check("pause_hold_data", data64, 128'h0000_0000_0000_0000_F7B3_D591_E6A2_C480);
    step(1'b0, 1'b1, 1'b1, 64'h1, 2'b01, 32'd0, 4'd0);
    after_edge();
    check("wrap_seq", 128'(seq64), 128'd0);
    check("one_data", data64, 128'h0000_0000_0000_0000_8000_0000_0000_0000);
    check("one_header", 128'(hdr64), 128'(6'b000010));
    check("no_underflow_yet", 128'(uf64), 128'd0);

    // Underflow at seq 5
    run_until_seq(5);
    rstep(1'b0, 1'b1, 1'b0);
    after_edge();
    check("uf_data", data64, 128'd0);
    check("uf_header", 128'(hdr64), 128'(6'b000010));
    check("uf_flag", 128'(uf64), 128'd1);

    // Random valid gaps
    repeat (60) rstep(1'b0, 1'b1, ($urandom_range(0, 3) != 0));

    // GT ready dropped at seq 17 for 3 cycles
    run_until_seq(17);
    rstep(1'b0, 1'b0, 1'b1);
    after_edge();
    check("drop_seq", 128'(seq64), 128'd0);
    check("drop_data", data64, 128'd0);
    check("drop_ready", 128'(lk64.tx_ready), 128'd0);
    repeat (2) rstep(1'b0, 1'b0, 1'b1);
    rstep(1'b0, 1'b1, 1'b1);
    after_edge();
    check("restart_seq", 128'(seq64), 128'd1);
    check("uf_sticky", 128'(uf64), 128'd1);

    // 8B10B mapping
    step(1'b0, 1'b1, 1'b1, rnd64(), 2'b01, 32'hBC50_BCBC, 4'b1011);
    after_edge();
    check("b8_data", data8, 128'h0000_0000_0000_0000_0000_0000_BC50_BCBC);
    check("b8_ctrl2", 128'(c2_8), 128'h0B);
    check("b8_seq", 128'(seq8), 128'd0);

    // Random GT ready and valid
    repeat (250) rstep(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) != 0));

    // Reset clears the sticky flag
    rstep(1'b1, 1'b1, 1'b1);
    after_edge();
    check("reset_clears_uf64", 128'(uf64), 128'd0);
    check("reset_clears_uf8", 128'(uf8), 128'd0);
    repeat (40) rstep(1'b0, 1'b1, 1'b1);

    after_edge();
    @(negedge usr_clk);
    check("scoreboard_drained", 128'(q64.size() + q8.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
